// File: rtl/shift_pkg.sv
// Shared encodings for the iterative shifter: operation modes and FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRA = 2'b01,
    MODE_ROR = 2'b10,
    MODE_ROL = 2'b11
  } shift_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift/rotate step.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_data,
  input  shift_mode_e      i_mode,
  output logic [WIDTH-1:0] o_data
);

  // The MSB is never altered by an SRA step, so it always equals the captured sign bit.
  always_comb begin
    o_data = i_data;
    case (i_mode)
      MODE_SLL: o_data = {i_data[WIDTH-2:0], 1'b0};
      MODE_SRA: o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
      MODE_ROR: o_data = {i_data[0], i_data[WIDTH-1:1]};
      MODE_ROL: o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
      default:  o_data = i_data;
    endcase
  end

endmodule

// File: rtl/iter_shift_unit.sv
// Iterative shifter: one bit position per cycle, valid/ready on both sides,
// synchronous flush of any in-flight request.
module iter_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [CNT_W-1:0] shift_val,
  input  logic [1:0]       mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shift_out,
  output logic             zero
);

  shift_state_e     r_state;
  shift_state_e     w_next_state;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_count;
  shift_mode_e      r_mode;
  logic [WIDTH-1:0] w_step;
  logic             w_accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_data (r_data),
    .i_mode (r_mode),
    .o_data (w_step)
  );

  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready && !flush;
  assign out_valid = (r_state == ST_DONE);
  assign shift_out = r_data;
  assign zero      = (r_state == ST_DONE) && (r_data == '0);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next_state = (shift_val == '0) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_count == CNT_W'(1)) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        if (w_accept)       w_next_state = (shift_val == '0) ? ST_DONE : ST_SHIFT;
        else if (out_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Flush overrides both a new accept and completion.
    if (flush) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_count <= '0;
      r_mode  <= MODE_SLL;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_data  <= shift_in;
      r_count <= shift_val;
      r_mode  <= shift_mode_e'(mode);
    end else if (r_state == ST_SHIFT) begin
      r_data  <= w_step;
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule
